uart_rx_fifo: RTL
=================

# uart_rx_fifo

UART receiver front end of the chip: takes the board-registered serial line, recovers 8N1 frames at a fixed cycles-per-bit rate, and buffers received bytes in a small first-word-fall-through FIFO. It is the upstream stage that feeds bytes to the core's input path. Overflow and framing errors are flagged through sticky bits that drive the debug signals.

## Interface
- START_SAMPLE, 433: cycles from detected start edge to the mid-start-bit sample.
- INTERVAL, 868: cycles per bit (100 MHz / 115200 baud).
- FIFO_LOG_DEPTH, 4: FIFO depth is 2**FIFO_LOG_DEPTH entries.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; one clock, synchronous, active-high reset, sampled on posedge clk.
- uart_rx  input  1  serial line, idle high; asynchronous to the bit timing.
- out_data  output  8  head byte of FIFO; valid only when out_valid.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head byte this cycle.
- frame_error  output  1  sticky: a stop bit was sampled low.
- overflow  output  1  sticky: a good byte was dropped because the FIFO was full.
- busy  output  1  FSM not in IDLE.

## Operation
- uart_rx passes through a 2-flop synchronizer, giving rx_s. rx_s resets to 1.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Bit counter `cnt` is 32 bits wide and saturates nowhere (all limits are below 2**31). Bit index `idx` is 3 bits.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: cnt increments each cycle. When cnt==START_SAMPLE-1:
  - if rx_s==0, go to DATA with cnt=0 and idx=0;
  - otherwise (glitch), return to IDLE with no side effects.
- DATA: when cnt==INTERVAL-1, sample rx_s into shift[idx] (LSB first) and set cnt=0. After idx==7, go to STOP; otherwise idx++.
- STOP: when cnt==INTERVAL-1, sample rx_s:
  - 1: push shift into FIFO, go to IDLE;
  - 0: set frame_error, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This covers break conditions.
- FIFO:
  - pop = out_valid && out_ready.
  - push is accepted when count<2**FIFO_LOG_DEPTH, or when pop occurs in the same cycle.
  - When full with no pop, the byte is dropped and overflow is set.
  - Pointers are FIFO_LOG_DEPTH bits and wrap naturally. count is FIFO_LOG_DEPTH+1 bits.
  - Simultaneous push and pop leaves count unchanged.
- out_data = mem[rd_ptr] combinationally (FWFT). out_valid = (count!=0).
- frame_error and overflow clear only on reset.
- Reset at any point, including mid-frame:
  - FSM=IDLE, cnt=0, idx=0;
  - FIFO emptied (pointers=0, count=0), so out_valid=0;
  - frame_error=0, overflow=0, busy=0. out_data is don't-care.
  - A frame in progress is abandoned. If the line is still low after reset, that low is treated as a new start edge.

## Timing
- uart_rx to rx_s: 2 cycles.
- Mid-start sample: START_SAMPLE cycles after the first cycle rx_s==0 is seen in IDLE.
- Each data sample is INTERVAL cycles after the previous sample. The stop sample occurs START_SAMPLE+9*INTERVAL cycles after start detection (8245 at defaults).
- out_valid rises in the cycle after the stop-sample cycle, i.e. 1 cycle FIFO write latency.
- Back-to-back frames are supported: IDLE is re-entered on the cycle after the stop sample, so a start edge there is detected.
- A pop is visible on the next posedge: rd_ptr advances and out_data shows the next byte.
- busy is high from the cycle after start detection through the stop sample (or through WAIT_HIGH).

## Test plan
Bench parameters: START_SAMPLE=7, INTERVAL=16, FIFO_LOG_DEPTH=2. Frames are driven at 16 cycles per bit.
- Single frame 0xA5 with out_ready=1: out_valid pulses for exactly 1 cycle with out_data=0xA5, 7+9*16+1 cycles after rx_s falls (+2 cycles synchronizer); both error flags remain 0.
- Start glitch (uart_rx low for 3 cycles, then high): FSM returns to IDLE, no byte is pushed, flags remain 0.
- Stop bit low on byte 0x3C, followed by line high: frame_error=1, FIFO stays empty, the next frame 0x81 is received correctly.
- out_ready=0, send 0x01..0x05 back to back: FIFO holds 0x01–0x04 and overflow=1. Raising out_ready then yields 0x01,0x02,0x03,0x04 on consecutive cycles, and out_valid falls afterwards.
- FIFO full, with a pop in the same cycle as the push of a 5th byte 0x55: the byte is accepted, overflow stays 0, and the drain order ends with ...,0x55.
- Assert reset mid-DATA of frame 0xFF: after reset all outputs are 0 and busy=0. A frame 0x12 sent after the line returns high is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 2-flop input synchronizer and a first-word-fall-through byte FIFO.
// Sticky frame_error/overflow flags clear only on reset.
module uart_rx_fifo #(
  parameter int unsigned START_SAMPLE   = 433,
  parameter int unsigned INTERVAL       = 868,
  parameter int unsigned FIFO_LOG_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_error,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  localparam int unsigned               DEPTH      = 1 << FIFO_LOG_DEPTH;
  localparam logic [31:0]               START_LAST = 32'(START_SAMPLE - 1);
  localparam logic [31:0]               BIT_LAST   = 32'(INTERVAL - 1);
  localparam logic [FIFO_LOG_DEPTH:0]   FULL_COUNT = (FIFO_LOG_DEPTH + 1)'(DEPTH);
  localparam logic [FIFO_LOG_DEPTH:0]   COUNT_ONE  = (FIFO_LOG_DEPTH + 1)'(1);
  localparam logic [FIFO_LOG_DEPTH-1:0] PTR_ONE    = FIFO_LOG_DEPTH'(1);

  logic [1:0] sync_q;
  logic       rx_s;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_error_q, frame_error_d;
  logic        push_req;

  logic [7:0]                mem [DEPTH];
  logic [FIFO_LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_LOG_DEPTH:0]   count_q;
  logic                      overflow_q;
  logic                      pop, push_ok;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_rx};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      frame_error_q <= frame_error_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    frame_error_d = frame_error_q;
    push_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign pop     = out_valid && out_ready;
  assign push_ok = push_req && ((count_q != FULL_COUNT) || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_req && !push_ok) overflow_q <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; count_q gates validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  assign out_data    = mem[rd_ptr_q];
  assign out_valid   = (count_q != '0);
  assign frame_error = frame_error_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != IDLE);

endmodule
